// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and types for the instruction fetch front end
package cpu_pkg;

    // addi x0, x0, 0: presented to decode whenever no fetched word is available
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        DRAIN
    } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with synchronous clear and occupancy count
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             head_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o      = (count_q == FULL_COUNT);
    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;
    assign head_data_o = mem_q[rd_ptr_q];
    assign do_push     = push_i && !full_o;
    assign do_pop      = pop_i && !empty_o;

    // Storage array: data only, no reset needed since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push && !clr_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers and count; clear and reset both empty the queue in one cycle
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - sequential PC fetch with credit-limited requests, redirect flush and stale-response drop
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INST_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  dec_ready,
    output logic                  inst_valid,
    output logic [INST_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0] inst_pc
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = ADDR_WIDTH + INST_WIDTH;
    localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]         out_q, out_d;
    logic [CW-1:0]         drop_q, drop_d;

    logic [CW-1:0]         fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [EW-1:0]         fifo_head;
    logic [ADDR_WIDTH-1:0] target_pc;
    logic                  credit_ok;
    logic                  req_fire;
    logic                  rsp_ok;
    logic                  push;
    logic                  pop;
    logic [1:0]            unused_redirect_lsbs;

    assign target_pc            = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign unused_redirect_lsbs = redirect_pc[1:0];

    // Words in the FIFO plus words still owed by memory never exceed DEPTH
    assign credit_ok      = ({1'b0, fifo_count} + {1'b0, out_q}) < CREDITS;
    assign imem_req_valid = !rst && (state_q != BOOT) && !redirect_valid && credit_ok;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a memory fault and is ignored
    assign rsp_ok = !rst && imem_rsp_valid && (out_q != '0);
    assign push   = rsp_ok && (drop_q == '0) && !redirect_valid && !fifo_full;

    assign inst_valid  = !rst && !fifo_empty;
    assign pop         = inst_valid && dec_ready && !redirect_valid;
    assign instruction = inst_valid ? fifo_head[INST_WIDTH-1:0] : INST_WIDTH'(NOP_INST);
    assign inst_pc     = inst_valid ? fifo_head[EW-1:INST_WIDTH] : '0;

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (redirect_valid),
        .push_i      (push),
        .push_data_i ({rsp_pc_q, imem_rsp_data}),
        .pop_i       (pop),
        .head_data_o (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Next-state for PCs and credit/drop counters; redirect overrides everything
    always_comb begin
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        out_d    = out_q + CW'(req_fire) - CW'(rsp_ok);
        drop_d   = drop_q;
        if (redirect_valid) begin
            pc_d     = target_pc;
            rsp_pc_d = target_pc;
            drop_d   = out_q - CW'(rsp_ok);
        end else begin
            if (req_fire) begin
                pc_d = pc_q + PC_STEP;
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + PC_STEP;
            end
            if (rsp_ok && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
        end
    end

    // Fetch FSM next-state: leave BOOT once, sit in DRAIN while stale words remain
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (redirect_valid && (drop_d != '0)) state_d = DRAIN;
            DRAIN:   if (drop_d == '0) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            out_q    <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_ready;
    logic        inst_valid;
    logic [31:0] instruction;
    logic [31:0] inst_pc;

    always #5 clk = ~clk;

    fetch_queue #(
        .ADDR_WIDTH (32),
        .INST_WIDTH (32),
        .DEPTH      (4),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_ready      (dec_ready),
        .inst_valid     (inst_valid),
        .instruction    (instruction),
        .inst_pc        (inst_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t pend[$];
    int    cyc_n    = 0;
    int    lat      = 1;
    int    inflight = 0;
    int    n_checks = 0;
    int    n_fail   = 0;
    int    nreq;

    // Memory returns the bitwise complement of the address as the instruction word
    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return ~pc;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    // Drive this cycle's memory response, then move to mid-cycle for sampling
    task automatic settle();
        if (rst) begin
            pend.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end else if (pend.size() > 0 && pend[0].due <= cyc_n) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_at(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        assert (!imem_rsp_valid || inflight > 0)
            else $error("FAIL rsp_without_request: inflight %0d", inflight);
        #4;
    endtask

    // Record handshakes seen this cycle and step to just after the next edge
    task automatic advance();
        mreq_t m;
        if (!rst && imem_req_valid && imem_req_ready) begin
            m.addr = imem_req_addr;
            m.due  = cyc_n + lat;
            pend.push_back(m);
            inflight++;
        end
        if (!rst && imem_rsp_valid) inflight--;
        if (rst) inflight = 0;
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    // One reset cycle; returns in the BOOT cycle with rst low
    task automatic do_reset(input int l);
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        dec_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        lat            = l;
        settle();
        advance();
        rst = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b0;
        @(posedge clk);
        #1;

        // Outputs while reset is held
        settle();
        check_eq("rst_req_valid", imem_req_valid, 0);
        check_eq("rst_inst_valid", inst_valid, 0);
        check_eq("rst_instruction", instruction, NOP_INST);
        check_eq("rst_inst_pc", inst_pc, 0);
        advance();

        // Streaming with 1-cycle memory and decode always ready
        do_reset(1);
        imem_req_ready = 1'b1;
        dec_ready      = 1'b1;
        for (int k = 0; k < 10; k++) begin
            settle();
            if (k == 0) begin
                check_eq("t1_boot_no_req", imem_req_valid, 0);
            end else begin
                check_eq("t1_req_valid", imem_req_valid, 1);
                check_eq("t1_req_addr", imem_req_addr, 32'((k - 1) * 4));
            end
            if (k < 3) begin
                check_eq("t1_inst_valid_low", inst_valid, 0);
            end else begin
                check_eq("t1_inst_valid", inst_valid, 1);
                check_eq("t1_inst_pc", inst_pc, 32'((k - 3) * 4));
                check_eq("t1_instr", instruction, word_at(32'((k - 3) * 4)));
            end
            advance();
        end

        // Decode stalled: credit limit caps requests at DEPTH
        do_reset(1);
        imem_req_ready = 1'b1;
        nreq = 0;
        for (int k = 0; k < 12; k++) begin
            dec_ready = (k == 8);
            settle();
            if (k >= 1 && k <= 7 && imem_req_valid) nreq++;
            if (k == 7) begin
                check_eq("t2_req_count", nreq, 4);
                check_eq("t2_req_stall", imem_req_valid, 0);
                check_eq("t2_inst_valid", inst_valid, 1);
                check_eq("t2_head_pc", inst_pc, 32'h0);
            end
            if (k == 8) check_eq("t2_full_no_req", imem_req_valid, 0);
            if (k == 9) begin
                check_eq("t2_credit_req", imem_req_valid, 1);
                check_eq("t2_credit_addr", imem_req_addr, 32'h10);
                check_eq("t2_new_head", inst_pc, 32'h4);
            end
            if (k == 10 || k == 11) check_eq("t2_one_credit_only", imem_req_valid, 0);
            advance();
        end

        // Latency 3 with two requests in flight, redirect to an unaligned target
        do_reset(3);
        imem_req_ready = 1'b1;
        dec_ready      = 1'b1;
        redirect_pc    = 32'h103;
        for (int k = 0; k < 16; k++) begin
            redirect_valid = (k == 8);
            settle();
            if (k == 6) check_eq("t3_addr_10", imem_req_addr, 32'h10);
            if (k == 7) check_eq("t3_addr_14", imem_req_addr, 32'h14);
            if (k == 8) check_eq("t3_redir_no_req", imem_req_valid, 0);
            if (k == 9) begin
                check_eq("t3_restart_valid", imem_req_valid, 1);
                check_eq("t3_restart_addr", imem_req_addr, 32'h100);
            end
            if (k >= 9 && k <= 12) check_eq("t3_drained_empty", inst_valid, 0);
            if (k == 13) begin
                check_eq("t3_first_valid", inst_valid, 1);
                check_eq("t3_first_pc", inst_pc, 32'h100);
                check_eq("t3_first_instr", instruction, word_at(32'h100));
            end
            if (k == 14) check_eq("t3_second_pc", inst_pc, 32'h104);
            advance();
        end
        redirect_valid = 1'b0;

        // Redirect coinciding with a response and a decode pop (latency 2)
        do_reset(2);
        imem_req_ready = 1'b1;
        dec_ready      = 1'b1;
        redirect_pc    = 32'h40;
        for (int k = 0; k < 12; k++) begin
            redirect_valid = (k == 5);
            settle();
            if (k == 5) begin
                check_eq("t4_head_before", inst_pc, 32'h4);
                check_eq("t4_redir_no_req", imem_req_valid, 0);
            end
            if (k == 6) check_eq("t4_restart_addr", imem_req_addr, 32'h40);
            if (k >= 6 && k <= 8) check_eq("t4_stale_dropped", inst_valid, 0);
            if (k == 9) begin
                check_eq("t4_first_pc", inst_pc, 32'h40);
                check_eq("t4_first_instr", instruction, word_at(32'h40));
            end
            if (k == 10) check_eq("t4_second_pc", inst_pc, 32'h44);
            advance();
        end
        redirect_valid = 1'b0;

        // Back-to-back redirects while draining: only the second stream survives
        do_reset(3);
        imem_req_ready = 1'b1;
        dec_ready      = 1'b1;
        for (int k = 0; k < 21; k++) begin
            redirect_valid = (k == 8 || k == 9);
            redirect_pc    = (k == 8) ? 32'h200 : 32'h300;
            settle();
            if (k == 9) check_eq("t5_second_redir_no_req", imem_req_valid, 0);
            if (k == 10) check_eq("t5_restart_addr", imem_req_addr, 32'h300);
            if (k >= 9 && k <= 13) check_eq("t5_empty", inst_valid, 0);
            if (k == 14) check_eq("t5_first_pc", inst_pc, 32'h300);
            if (k == 15) check_eq("t5_second_pc", inst_pc, 32'h304);
            if (k >= 10 && inst_valid) check_eq("t5_stream", inst_pc & 32'hF00, 32'h300);
            advance();
        end
        redirect_valid = 1'b0;

        // Reset mid-operation with buffered words and requests outstanding
        do_reset(3);
        imem_req_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            settle();
            if (k == 5) check_eq("t6_busy_before_rst", inst_valid, 1);
            advance();
        end
        rst = 1'b1;
        settle();
        check_eq("t6_in_rst_req", imem_req_valid, 0);
        check_eq("t6_in_rst_valid", inst_valid, 0);
        advance();
        rst            = 1'b0;
        lat            = 1;
        dec_ready      = 1'b1;
        settle();
        check_eq("t6_after_valid", inst_valid, 0);
        check_eq("t6_after_instr", instruction, NOP_INST);
        check_eq("t6_after_pc", inst_pc, 0);
        check_eq("t6_after_req", imem_req_valid, 0);
        advance();
        for (int k = 1; k < 5; k++) begin
            settle();
            check_eq("t6_restart_addr", imem_req_addr, 32'((k - 1) * 4));
            if (k == 3) check_eq("t6_first_pc", inst_pc, 32'h0);
            if (k == 4) check_eq("t6_second_pc", inst_pc, 32'h4);
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
